// File: rtl/bcd_updown_counter_nd.sv
// N-digit 8421-BCD up/down counter with programmable inclusive terminal value,
// synchronous preset, wrap/saturate mode and a sticky illegal-BCD flag.

module bcd_digit_nd (
  input  logic [3:0] q,
  input  logic [3:0] d,
  input  logic [3:0] mx,
  input  logic       ci,
  input  logic       bi,
  output logic [3:0] inc,
  output logic [3:0] dec,
  output logic       d_ok,
  output logic       m_ok,
  output logic       nine,
  output logic       zero
);
  assign nine = (q == 4'd9);
  assign zero = (q == 4'd0);
  assign d_ok = (d <= 4'd9);
  assign m_ok = (mx <= 4'd9);
  assign inc  = !ci ? q : (nine ? 4'd0 : q + 4'd1);
  assign dec  = !bi ? q : (zero ? 4'd9 : q - 4'd1);
endmodule

module bcd_updown_counter_nd #(
  parameter int DIGITS = 2,
  parameter int W      = 4*DIGITS
) (
  input  logic         CP,
  input  logic         CR,
  input  logic         CE,
  input  logic         PE,
  input  logic         UP,
  input  logic         MODE,
  input  logic [W-1:0] D,
  input  logic [W-1:0] MAX,
  output logic [W-1:0] Q,
  output logic         TC,
  output logic         ERR
);
  logic [DIGITS-1:0] cy, bw, d_ok, m_ok, nine, zero;
  logic [W-1:0]      q_inc, q_dec, q_nxt;
  logic              err_nxt, d_legal, max_legal, q_zero, q_eq_max, q_lt_max;

  // Ripple carry/borrow: a digit steps only when every lower digit rolls over.
  assign cy[0] = 1'b1;
  assign bw[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_dig
      if (i > 0) begin : g_chain
        assign cy[i] = cy[i-1] & nine[i-1];
        assign bw[i] = bw[i-1] & zero[i-1];
      end
      bcd_digit_nd u_dig (
        .q   (Q[4*i +: 4]),
        .d   (D[4*i +: 4]),
        .mx  (MAX[4*i +: 4]),
        .ci  (cy[i]),
        .bi  (bw[i]),
        .inc (q_inc[4*i +: 4]),
        .dec (q_dec[4*i +: 4]),
        .d_ok(d_ok[i]),
        .m_ok(m_ok[i]),
        .nine(nine[i]),
        .zero(zero[i])
      );
    end
  endgenerate

  assign d_legal   = &d_ok;
  assign max_legal = &m_ok;
  assign q_zero    = &zero;
  assign q_eq_max  = (Q == MAX);
  assign q_lt_max  = (Q < MAX);

  assign TC = CE & ~PE & max_legal & ((UP & q_eq_max) | (~UP & q_zero));

  always_comb begin
    q_nxt   = Q;
    err_nxt = ERR;
    if (PE) begin
      if (d_legal) begin
        q_nxt   = D;
        err_nxt = 1'b0;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (CE) begin
      if (!max_legal) begin
        err_nxt = 1'b1;
      end else if (UP) begin
        if (q_lt_max)                 q_nxt = q_inc;
        else if (!(q_eq_max && MODE)) q_nxt = '0;
      end else begin
        // Above MAX snaps to MAX regardless of mode.
        if (!q_lt_max && !q_eq_max)   q_nxt = MAX;
        else if (q_zero)              q_nxt = MODE ? Q : MAX;
        else                          q_nxt = q_dec;
      end
    end
  end

  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      Q   <= '0;
      ERR <= 1'b0;
    end else begin
      Q   <= q_nxt;
      ERR <= err_nxt;
    end
  end
endmodule

// File: tb/tb_bcd_updown_counter_nd.sv
// Scoreboard bench for bcd_updown_counter_nd (DIGITS=2): a decimal-integer
// reference model pushes expected {ERR,Q} per edge; TC is checked combinationally.

module tb_bcd_updown_counter_nd;
  localparam int DIGITS = 2;
  localparam int W = 4*DIGITS;

  logic         CP = 1'b0, CR = 1'b0, CE = 1'b0, PE = 1'b0, UP = 1'b1, MODE = 1'b0;
  logic [W-1:0] D = '0, MAX = 8'h99;
  logic [W-1:0] Q;
  logic         TC, ERR;

  int n_tests = 0, n_fail = 0;
  logic [W:0]   sbq[$];
  logic [W-1:0] mq = '0;
  logic         merr = 1'b0;

  bcd_updown_counter_nd #(.DIGITS(DIGITS)) dut (
    .CP(CP), .CR(CR), .CE(CE), .PE(PE), .UP(UP), .MODE(MODE),
    .D(D), .MAX(MAX), .Q(Q), .TC(TC), .ERR(ERR)
  );

  always #5 CP = ~CP;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [W-1:0] v);
    for (int k = 0; k < DIGITS; k++) if (v[4*k +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int b2i(input logic [W-1:0] v);
    int r = 0;
    for (int k = DIGITS-1; k >= 0; k--) r = r*10 + int'(v[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] i2b(input int n);
    logic [W-1:0] r = '0;
    int t = n;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Drive one cycle's inputs, check TC, predict the edge, then compare after it.
  task automatic step(input logic ce, pe, up, mode, input logic [W-1:0] d, mx);
    logic [W:0] e;
    logic etc;
    int qi, mi;
    CE = ce; PE = pe; UP = up; MODE = mode; D = d; MAX = mx;
    #1;
    qi  = b2i(mq);
    mi  = b2i(mx);
    etc = ce && !pe && legal(mx) && ((up && qi == mi) || (!up && qi == 0));
    chk("tc", TC, etc);
    if (pe) begin
      if (legal(d)) begin mq = d; merr = 1'b0; end
      else merr = 1'b1;
    end else if (ce) begin
      if (!legal(mx)) merr = 1'b1;
      else if (up) begin
        if (qi < mi) mq = i2b(qi + 1);
        else if (!(qi == mi && mode)) mq = '0;
      end else begin
        if (qi > mi) mq = mx;
        else if (qi == 0) mq = mode ? mq : mx;
        else mq = i2b(qi - 1);
      end
    end
    sbq.push_back({merr, mq});
    @(posedge CP);
    #1;
    if (sbq.size() == 0) chk("sb_empty", 1, 0);
    else begin
      e = sbq.pop_front();
      chk("q", Q, e[W-1:0]);
      chk("err", ERR, e[W]);
      chk("q_bcd", legal(Q), 1);
    end
  endtask

  initial begin
    // Power-on reset
    #12;
    chk("rst_q", Q, 0);
    chk("rst_err", ERR, 0);
    CR = 1'b1;

    // 1: set ERR, count to 0x37, then asynchronous clear between edges
    step(0, 1, 1, 0, 8'h30, 8'h99);
    step(0, 1, 1, 0, 8'h3A, 8'h99);
    repeat (7) step(1, 0, 1, 0, 8'h00, 8'h99);
    chk("at37", Q, 8'h37);
    chk("err_set", ERR, 1);
    #2 CR = 1'b0;
    #1;
    chk("clr_q", Q, 0);
    chk("clr_err", ERR, 0);
    mq = '0; merr = 1'b0;
    CE = 1'b1;
    @(posedge CP); #1;
    chk("clr_hold_q", Q, 0);
    CR = 1'b1;
    step(1, 0, 1, 0, 8'h00, 8'h99);
    chk("resume", Q, 8'h01);

    // 2: up/wrap period with MAX=0x40
    step(0, 1, 1, 0, 8'h00, 8'h40);
    repeat (41) step(1, 0, 1, 0, 8'h00, 8'h40);
    chk("period41", Q, 8'h00);

    // 3: down/wrap from 0 -> MAX, then through 0x10 -> 0x09
    step(1, 0, 0, 0, 8'h00, 8'h40);
    chk("dn_wrap", Q, 8'h40);
    repeat (31) step(1, 0, 0, 0, 8'h00, 8'h40);
    chk("dn_09", Q, 8'h09);

    // 4: preset and error
    step(0, 1, 1, 0, 8'h05, 8'h40);
    step(0, 1, 1, 0, 8'h1A, 8'h40);
    repeat (5) step(1, 0, 1, 0, 8'h00, 8'h40);
    step(0, 1, 1, 0, 8'h12, 8'h40);
    chk("pre12", Q, 8'h12);
    step(1, 0, 1, 0, 8'h00, 8'h4F);
    step(1, 0, 1, 0, 8'h00, 8'h4F);

    // 5: saturate
    step(0, 1, 1, 1, 8'h39, 8'h40);
    step(1, 0, 1, 1, 8'h00, 8'h40);
    repeat (3) step(1, 0, 1, 1, 8'h00, 8'h40);
    chk("sat_hi", Q, 8'h40);
    repeat (42) step(1, 0, 0, 1, 8'h00, 8'h40);
    chk("sat_lo", Q, 8'h00);

    // 6: out of range above MAX, PE+CE together, MAX=0 corner
    step(0, 1, 1, 0, 8'h55, 8'h40);
    step(1, 0, 1, 0, 8'h00, 8'h40);
    chk("oor_up", Q, 8'h00);
    step(0, 1, 1, 0, 8'h55, 8'h40);
    step(1, 0, 0, 0, 8'h00, 8'h40);
    chk("oor_dn", Q, 8'h40);
    step(1, 1, 1, 0, 8'h07, 8'h40);
    chk("pe_ce", Q, 8'h07);
    step(0, 1, 1, 0, 8'h00, 8'h00);
    repeat (2) step(1, 0, 1, 0, 8'h00, 8'h00);
    repeat (2) step(1, 0, 0, 1, 8'h00, 8'h00);

    // Random mix over legal and occasionally illegal operands
    repeat (200) begin
      logic [W-1:0] rd, rm;
      rd = ($urandom_range(0, 15) == 0) ? W'($urandom) : i2b($urandom_range(0, 99));
      rm = ($urandom_range(0, 15) == 0) ? W'($urandom) : i2b($urandom_range(0, 99));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
           1'($urandom), 1'($urandom), rd, rm);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_updown_counter_nd.md
Name: bcd_updown_counter_nd

Overview:
Parametrised N-digit 8421-BCD reversible counter with programmable inclusive terminal value MAX.
- Synchronous parallel preset; asynchronous active-low clear.
- Selectable wrap or saturate mode; illegal-BCD error flag.
- Digit count generalised so a single block serves timers, displays and event counters in the curriculum designs; TC allows cascading.

Parameters:
DIGITS, 2, number of BCD digits; data width W = 4*DIGITS

Ports:
CP  input  1  clock, rising-edge active
CR  input  1  clear; asynchronous, active-low: CR=0 forces Q=0, ERR=0 immediately
CE  input  1  count enable, high active; Q holds when low
PE  input  1  synchronous preset, high active; overrides CE
UP  input  1  direction: 1 up, 0 down
MODE  input  1  0 wrap, 1 saturate (stop at terminal)
D  input  W  preset data, BCD digits
MAX  input  W  terminal value, BCD; count range 0..MAX inclusive
Q  output  W  count, BCD digits
TC  output  1  terminal count, combinational
ERR  output  1  registered illegal-BCD flag

Behaviour:
- Reset (CR=0, asynchronous): Q=0, ERR=0. While CR=0 the clock is ignored. CR release is synchronous-safe: the first counting edge occurs after release.
- Priority at each rising CP edge: PE > CE > hold.
- PE=1, D legal BCD (every nibble <=9):
  - Q<=D, ERR<=0, regardless of CE, UP and MODE.
  - D>MAX is loaded as-is.
- PE=1, D illegal (any nibble >9): Q holds, ERR<=1.
- CE=1, PE=0, MAX illegal: Q holds, ERR<=1.
- CE=1, PE=0, MAX legal:
  - UP=1, Q<MAX: Q<=Q+1 in BCD. Per digit, 9 -> 0 with carry into the next digit; e.g. 09->10, 99->00 only if MAX=99.
  - UP=1, Q==MAX: MODE=0 gives Q<=0; MODE=1 gives Q holds.
  - UP=1, Q>MAX (after preset or MAX change): Q<=0 in both modes.
  - UP=0, Q>0 and Q<=MAX: Q<=Q-1 in BCD. Per digit, 0 -> 9 with borrow; e.g. 10->09.
  - UP=0, Q==0: MODE=0 gives Q<=MAX; MODE=1 gives Q holds.
  - UP=0, Q>MAX: Q<=MAX in both modes.
- CE=0, PE=0: Q and ERR hold.
- ERR is sticky. It clears only on reset or a legal preset.
- TC = CE & ~PE & ((UP & Q==MAX) | (~UP & Q==0)).
  - Combinational from the current Q; no latency.
  - Stays high every enabled cycle while saturated at terminal.
  - Forced 0 when MAX is illegal.
- MAX=0: Q stays 0 (wrap or saturate); TC=1 on every enabled cycle.
- Comparisons Q vs MAX: unsigned on the packed BCD vector, which is order-preserving for legal BCD.
- UP, MODE and MAX may change on any cycle. The next edge uses the values present at that edge.
- Cascade: TC of a lower instance drives CE of the upper instance, both on a shared CP.
- Synthesisable; no latches; W-bit datapath built with a per-digit generate loop.

Test Plan:
All cases use DIGITS=2 and hex-coded BCD.
1. Reset mid-operation: count to Q=0x37, pull CR low between edges -> Q=0x00 and ERR=0 immediately; no change on the next CP while CR=0; counting resumes from 0x00 after release.
2. Up/wrap, MAX=0x40, MODE=0, CE=1, UP=1 from 0x00:
   - Q passes 0x09->0x10 and 0x39->0x40.
   - TC=1 only while Q=0x40; the next edge gives Q=0x00.
   - Exactly 41 edges per period.
3. Down/wrap, MAX=0x40, UP=0 from Q=0x00:
   - TC=1; the next edge gives Q=0x40.
   - Later 0x10->0x09; no non-BCD value ever appears on Q.
4. Preset and error:
   - CE=0, PE=1, D=0x05 -> Q=0x05.
   - PE=1, D=0x1A -> Q stays 0x05, ERR=1; ERR stays 1 over 5 counting edges.
   - PE=1, D=0x12 -> Q=0x12, ERR=0.
   - MAX=0x4F with CE=1 -> Q holds, ERR=1, TC=0.
5. Saturate, MODE=1, MAX=0x40, UP=1 from 0x39:
   - Q=0x40, then holds for 3 edges with TC=1 each cycle.
   - UP=0 -> Q=0x39; down to 0x00 holds with TC=1.
6. Out of range: preset 0x55 with MAX=0x40 -> UP=1 edge gives Q=0x00; re-preset 0x55 -> UP=0 edge gives Q=0x40. PE=1 and CE=1 simultaneously with D=0x07 -> Q=0x07 and TC=0 that cycle.
